// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared encodings for the SPI burst sequencer and its bus wrapper
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_RX  = 3'd3,
    ST_WAIT_RDY = 3'd4,
    ST_CS_HOLD  = 3'd5
  } seq_state_e;

  localparam logic [7:0] SPI_FILL_DEFAULT = 8'hFF;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with registered full/empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic [WIDTH-1:0] last_q;
  logic             push;
  logic             pop;

  assign push = wr_en & ~full;
  assign pop  = rd_en & ~empty;

  always_comb begin
    count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // last_q keeps the most recently popped word visible once the FIFO drains
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      last_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  assign rd_data = empty ? last_q : mem[rd_ptr];

endmodule

// File: rtl/spi_burst_sequencer.sv
// rtl/spi_burst_sequencer.sv - turns an N-byte request into single-byte handshakes
// for the SPI byte master, owning chip-select timing and TX/RX buffering.
module spi_burst_sequencer
  import spi_pkg::*;
#(
  parameter int         FIFO_DEPTH   = 16,
  parameter int         LEN_W        = 8,
  parameter int         CS_SETUP_CYC = 2,
  parameter int         CS_HOLD_CYC  = 2,
  parameter logic [7:0] FILL_BYTE    = SPI_FILL_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] xfer_len,
  input  logic             rx_keep,
  input  logic             tx_wr_en,
  input  logic [7:0]       tx_wr_data,
  output logic             tx_full,
  input  logic             rx_rd_en,
  output logic [7:0]       rx_rd_data,
  output logic             rx_empty,
  output logic             busy,
  output logic             done,
  output logic             rx_ovf,
  output logic [7:0]       spi_tx_byte,
  output logic             spi_tx_dv,
  input  logic             spi_tx_ready,
  input  logic             spi_rx_dv,
  input  logic [7:0]       spi_rx_byte,
  output logic             spi_cs_n
);

  localparam int TMR_W = 16;

  seq_state_e       state;
  seq_state_e       state_d;
  logic [LEN_W-1:0] remaining;
  logic             keep_q;
  logic [TMR_W-1:0] timer;

  logic             start_ok;
  logic             issue_ok;
  logic             rx_hit;
  logic             rx_push;
  logic             ovf_set;
  logic             tx_pop;
  logic             cs_n_d;
  logic             dv_d;
  logic             done_d;
  logic [7:0]       byte_d;

  logic [7:0]       tx_head;
  logic             tx_empty;
  logic             rx_full;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (tx_wr_en),
    .wr_data (tx_wr_data),
    .full    (tx_full),
    .rd_en   (tx_pop),
    .rd_data (tx_head),
    .empty   (tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (rx_push),
    .wr_data (spi_rx_byte),
    .full    (rx_full),
    .rd_en   (rx_rd_en),
    .rd_data (rx_rd_data),
    .empty   (rx_empty)
  );

  assign start_ok = (state == ST_IDLE) && start && (xfer_len != '0);
  // The last setup cycle may issue directly so the first DV lands exactly CS_SETUP_CYC after CS falls
  assign issue_ok = spi_tx_ready &&
                    ((state == ST_ISSUE) || ((state == ST_CS_SETUP) && (timer == '0)));
  assign rx_hit   = (state == ST_WAIT_RX) && spi_rx_dv;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:     if (start_ok) state_d = ST_CS_SETUP;
      ST_CS_SETUP: if (timer == '0) state_d = issue_ok ? ST_WAIT_RX : ST_ISSUE;
      ST_ISSUE:    if (issue_ok) state_d = ST_WAIT_RX;
      ST_WAIT_RX:  if (spi_rx_dv) state_d = ST_WAIT_RDY;
      ST_WAIT_RDY: if (spi_tx_ready) state_d = (remaining != '0) ? ST_ISSUE : ST_CS_HOLD;
      ST_CS_HOLD:  if (timer == '0) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cs_n_d  = (state_d == ST_IDLE);
    done_d  = (state == ST_CS_HOLD) && (timer == '0);
    dv_d    = issue_ok;
    byte_d  = spi_tx_byte;
    tx_pop  = issue_ok && !tx_empty;
    rx_push = rx_hit && keep_q;
    ovf_set = rx_push && rx_full;
    if (issue_ok) begin
      byte_d = tx_empty ? FILL_BYTE : tx_head;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      remaining   <= '0;
      keep_q      <= 1'b0;
      timer       <= '0;
      rx_ovf      <= 1'b0;
      spi_cs_n    <= 1'b1;
      spi_tx_dv   <= 1'b0;
      spi_tx_byte <= 8'h00;
      done        <= 1'b0;
    end else begin
      spi_cs_n    <= cs_n_d;
      spi_tx_dv   <= dv_d;
      spi_tx_byte <= byte_d;
      done        <= done_d;

      if (start_ok) begin
        remaining <= xfer_len;
        keep_q    <= rx_keep;
      end else if (rx_hit && (remaining != '0)) begin
        remaining <= remaining - LEN_W'(1);
      end

      if (start_ok) begin
        timer <= TMR_W'(CS_SETUP_CYC - 1);
      end else if ((state == ST_WAIT_RDY) && (state_d == ST_CS_HOLD)) begin
        timer <= TMR_W'(CS_HOLD_CYC - 1);
      end else if (((state == ST_CS_SETUP) || (state == ST_CS_HOLD)) && (timer != '0)) begin
        timer <= timer - TMR_W'(1);
      end

      if (start_ok) begin
        rx_ovf <= 1'b0;
      end else if (ovf_set) begin
        rx_ovf <= 1'b1;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// tb/tb_spi_burst_sequencer.sv - scoreboard bench for spi_burst_sequencer with a
// loopback byte-master model (MISO tied to MOSI).
module tb_spi_burst_sequencer;

  localparam int DEPTH    = 4;
  localparam int SETUP    = 3;
  localparam int HOLD     = 5;
  localparam int BT       = 4;
  // master busy for 5 cycles per byte (ready drops after DV, returns one cycle after RX_DV)
  localparam int BYTE_GAP = 5 + 2;
  // RX_DV -> ready one cycle later -> WAIT_RDY -> CS_HOLD cycles -> CS_N rise
  localparam int HOLD_GAP = HOLD + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] xfer_len = 8'd0;
  logic       rx_keep = 1'b0;
  logic       tx_wr_en = 1'b0;
  logic [7:0] tx_wr_data = 8'd0;
  logic       tx_full;
  logic       rx_rd_en = 1'b0;
  logic [7:0] rx_rd_data;
  logic       rx_empty;
  logic       busy;
  logic       done;
  logic       rx_ovf;
  logic [7:0] spi_tx_byte;
  logic       spi_tx_dv;
  logic       spi_tx_ready;
  logic       spi_rx_dv;
  logic [7:0] spi_rx_byte;
  logic       spi_cs_n;

  spi_burst_sequencer #(
    .FIFO_DEPTH(DEPTH), .LEN_W(8), .CS_SETUP_CYC(SETUP), .CS_HOLD_CYC(HOLD), .FILL_BYTE(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .xfer_len(xfer_len), .rx_keep(rx_keep),
    .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .tx_full(tx_full),
    .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data), .rx_empty(rx_empty),
    .busy(busy), .done(done), .rx_ovf(rx_ovf),
    .spi_tx_byte(spi_tx_byte), .spi_tx_dv(spi_tx_dv), .spi_tx_ready(spi_tx_ready),
    .spi_rx_dv(spi_rx_dv), .spi_rx_byte(spi_rx_byte), .spi_cs_n(spi_cs_n)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int dv_cnt = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // loopback byte master
  logic [7:0] m_shift;
  int         m_cnt;
  always @(posedge clk) begin
    if (reset) begin
      spi_tx_ready <= 1'b1;
      spi_rx_dv    <= 1'b0;
      spi_rx_byte  <= 8'h00;
      m_shift      <= 8'h00;
      m_cnt        <= 0;
    end else begin
      spi_rx_dv <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 2) begin
          spi_rx_dv   <= 1'b1;
          spi_rx_byte <= m_shift;
        end
        if (m_cnt == 1) spi_tx_ready <= 1'b1;
      end else if (spi_tx_dv && spi_tx_ready) begin
        spi_tx_ready <= 1'b0;
        m_shift      <= spi_tx_byte;
        m_cnt        <= BT;
      end
    end
  end

  // monitor / scoreboard
  logic prev_cs = 1'b1;
  logic prev_dv = 1'b0;
  int   cs_fall = 0;
  int   last_dv = -1;
  int   last_rxdv = 0;
  bit   setup_pend = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_cs    = 1'b1;
      prev_dv    = 1'b0;
      last_dv    = -1;
      setup_pend = 1'b0;
    end else begin
      if (!spi_cs_n && prev_cs) begin
        cs_fall    = cyc;
        setup_pend = 1'b1;
      end
      if (spi_rx_dv) last_rxdv = cyc;
      if (spi_tx_dv) begin
        dv_cnt++;
        if (exp_tx.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_extra: got byte %0h expected no DV (cycle %0d)", spi_tx_byte, cyc);
        end else begin
          chk("tx_byte", spi_tx_byte, exp_tx.pop_front());
        end
        chk("dv_when_ready", spi_tx_ready, 1);
        chk("dv_single", prev_dv, 0);
        if (setup_pend) begin
          chk("cs_setup", cyc - cs_fall, SETUP);
          setup_pend = 1'b0;
        end else if (last_dv >= 0) begin
          chk("byte_gap", cyc - last_dv, BYTE_GAP);
        end
        last_dv = cyc;
      end
      if (rx_rd_en && !rx_empty) begin
        if (exp_rx.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rx_extra: got %0h expected empty (cycle %0d)", rx_rd_data, cyc);
        end else begin
          chk("rx_data", rx_rd_data, exp_rx.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_with_cs_rise", {prev_cs, spi_cs_n}, 2'b01);
        chk("cs_hold", cyc - last_rxdv, HOLD_GAP);
      end
      if (spi_cs_n && !prev_cs) last_dv = -1;
      prev_cs = spi_cs_n;
      prev_dv = spi_tx_dv;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic write_tx(input logic [7:0] b);
    @(posedge clk); #1 tx_wr_en = 1'b1; tx_wr_data = b;
    @(posedge clk); #1 tx_wr_en = 1'b0;
  endtask

  task automatic read_rx();
    @(posedge clk); #1 rx_rd_en = 1'b1;
    @(posedge clk); #1 rx_rd_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] len, input logic keep);
    @(posedge clk); #1 start = 1'b1; xfer_len = len; rx_keep = keep;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic start_xfer(input logic [7:0] len, input logic keep);
    pulse_start(len, keep);
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    chk("cs_low_after_start", spi_cs_n, 0);
  endtask

  task automatic wait_done(input int n0);
    int k = 0;
    while (done_cnt == n0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt == n0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done after %0d cycles expected one", k);
    end else begin
      repeat (3) @(negedge clk);
      chk("done_once", done_cnt - n0, 1);
      chk("busy_dropped", busy, 0);
      chk("cs_idle_high", spi_cs_n, 1);
    end
  endtask

  initial begin
    int n0;
    int len;
    int k;
    do_reset();
    @(negedge clk);
    chk("rst_cs_n", spi_cs_n, 1);
    chk("rst_tx_dv", spi_tx_dv, 0);
    chk("rst_tx_byte", spi_tx_byte, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rx_ovf", rx_ovf, 0);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_rx_empty", rx_empty, 1);
    chk("rst_rx_rd_data", rx_rd_data, 0);

    // two-byte kept burst
    write_tx(8'hA5);
    write_tx(8'h3C);
    exp_tx.push_back(8'hA5); exp_tx.push_back(8'h3C);
    exp_rx.push_back(8'hA5); exp_rx.push_back(8'h3C);
    n0 = done_cnt;
    start_xfer(8'd2, 1'b1);
    wait_done(n0);
    chk("rx_not_empty", rx_empty, 0);
    read_rx();
    read_rx();
    @(negedge clk);
    chk("rx_drained", rx_empty, 1);
    chk("rx_hold_last", rx_rd_data, 8'h3C);
    read_rx();
    @(negedge clk);
    chk("rx_read_empty_holds", rx_rd_data, 8'h3C);

    // empty TX FIFO sends fill bytes
    repeat (3) exp_tx.push_back(8'hFF);
    n0 = done_cnt;
    start_xfer(8'd3, 1'b0);
    wait_done(n0);
    chk("fill_no_ovf", rx_ovf, 0);
    chk("fill_not_kept", rx_empty, 1);

    // RX overflow with a full TX FIFO and a dropped write
    for (int i = 1; i <= 4; i++) write_tx(8'(i));
    @(negedge clk);
    chk("tx_full_set", tx_full, 1);
    write_tx(8'h99);
    for (int i = 1; i <= 4; i++) begin
      exp_tx.push_back(8'(i));
      exp_rx.push_back(8'(i));
    end
    exp_tx.push_back(8'hFF); exp_tx.push_back(8'hFF);
    n0 = done_cnt;
    start_xfer(8'd6, 1'b1);
    wait_done(n0);
    chk("ovf_set", rx_ovf, 1);
    for (int i = 0; i < 4; i++) read_rx();
    @(negedge clk);
    chk("ovf_rx_drained", rx_empty, 1);
    exp_tx.push_back(8'hFF);
    n0 = done_cnt;
    start_xfer(8'd1, 1'b0);
    chk("ovf_cleared_by_start", rx_ovf, 0);
    wait_done(n0);

    // zero-length start is ignored
    n0 = done_cnt;
    pulse_start(8'd0, 1'b1);
    @(negedge clk);
    chk("zero_len_busy", busy, 0);
    chk("zero_len_cs", spi_cs_n, 1);
    repeat (20) @(negedge clk);
    chk("zero_len_no_done", done_cnt - n0, 0);

    // start while busy is ignored
    exp_tx.push_back(8'hFF); exp_tx.push_back(8'hFF);
    n0 = done_cnt;
    start_xfer(8'd2, 1'b0);
    repeat (4) @(negedge clk);
    pulse_start(8'd5, 1'b1);
    wait_done(n0);
    repeat (30) @(negedge clk);
    chk("busy_start_no_extra_done", done_cnt - n0, 1);

    // reset during byte 2 of a 4-byte burst
    for (int i = 0; i < 4; i++) write_tx(8'h11 * 8'(i + 1));
    exp_tx.push_back(8'h11); exp_tx.push_back(8'h22);
    n0 = done_cnt;
    k = dv_cnt;
    start_xfer(8'd4, 1'b1);
    len = 0;
    while (dv_cnt < k + 2 && len < 200) begin
      @(negedge clk);
      len++;
    end
    chk("reached_byte2", dv_cnt - k, 2);
    chk("rx_byte1_stored", rx_empty, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_cs_n", spi_cs_n, 1);
    chk("midrst_rx_empty", rx_empty, 1);
    chk("midrst_tx_full", tx_full, 0);
    chk("midrst_busy", busy, 0);
    repeat (20) @(negedge clk);
    chk("midrst_no_done", done_cnt - n0, 0);
    exp_tx.push_back(8'hFF);
    n0 = done_cnt;
    start_xfer(8'd1, 1'b0);
    wait_done(n0);

    // random-length burst
    len = $urandom_range(2, 9);
    for (int i = 0; i < len; i++) exp_tx.push_back(8'hFF);
    n0 = done_cnt;
    k = dv_cnt;
    start_xfer(8'(len), 1'b0);
    wait_done(n0);
    chk("rand_byte_count", dv_cnt - k, len);

    chk("tx_queue_empty", exp_tx.size(), 0);
    chk("rx_queue_empty", exp_rx.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
